// File: rtl/int_pkg.sv
// ----------------------------------------------------------------------------
// int_pkg -- shared definitions for the int_ctrl interrupt controller.
//   state_e        : controller state (IDLE / REQ / SERVICE)
//   N_SRC_DEFAULT  : default number of interrupt sources
// ----------------------------------------------------------------------------
package int_pkg;

  localparam int N_SRC_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

endpackage : int_pkg

// File: rtl/int_arb.sv
// ----------------------------------------------------------------------------
// int_arb -- combinational interrupt arbiter.
// Searches the request vector starting at index ptr and wrapping modulo N_SRC;
// the first set bit wins. Driving ptr with a pointer register gives
// round-robin arbitration; tying ptr to zero gives fixed priority where the
// lowest set index wins.
//   req   [N_SRC-1:0] : enabled pending requests
//   ptr   [VEC_W-1:0] : search start index (must be < N_SRC)
//   grant [VEC_W-1:0] : winning index (0 when nothing is requested)
//   valid             : at least one request is set
// ----------------------------------------------------------------------------
module int_arb
  import int_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  parameter int VEC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [VEC_W-1:0] ptr,
  output logic [VEC_W-1:0] grant,
  output logic             valid
);

  always_comb begin : search
    int idx;
    // NOTE: every output of a combinational block gets a default first so
    // that no path through the block leaves it unassigned (no latch).
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = VEC_W'(idx);
      end
    end
  end

endmodule : int_arb

// File: rtl/int_ctrl.sv
// ----------------------------------------------------------------------------
// int_ctrl -- pending-latch interrupt controller with a three-state handshake.
// Source pulses latch into pending bits; an enabled pending source is
// presented to the CPU on irq/irq_vec, acknowledged with irq_ack (clears its
// pending bit) and closed with eoi.
//
// Build option: define INT_CTRL_RR_EN for round-robin arbitration (search
// starts at a pointer that moves past each acknowledged source). Without it,
// the lowest enabled pending index always wins and no pointer is kept.
//
// Ports:
//   clk                   : system clock, rising edge
//   rst                   : asynchronous active-high reset
//   int_src  [N_SRC-1:0]  : one-cycle request pulses per source
//   mask_in  [N_SRC-1:0]  : new enable mask (1 = enabled)
//   mask_we               : load mask_in this cycle
//   irq_ack               : CPU acknowledge (honoured in REQ only)
//   eoi                   : CPU end-of-interrupt (honoured in SERVICE only)
//   irq                   : registered interrupt request
//   irq_vec  [VEC_W-1:0]  : index of the presented / in-service source
//   in_service            : high while in SERVICE
//   pending  [N_SRC-1:0]  : latched pending bits
// ----------------------------------------------------------------------------
module int_ctrl
  import int_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  parameter int VEC_W = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] int_src,
  input  logic [N_SRC-1:0] mask_in,
  input  logic             mask_we,
  input  logic             irq_ack,
  input  logic             eoi,
  output logic             irq,
  output logic [VEC_W-1:0] irq_vec,
  output logic             in_service,
  output logic [N_SRC-1:0] pending
);

  state_e             state_q, state_d;
  logic               irq_q, irq_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   clr;

  logic [VEC_W-1:0]   arb_ptr;
  logic [VEC_W-1:0]   arb_grant;
  logic               arb_valid;

  int_arb #(
    .N_SRC (N_SRC),
    .VEC_W (VEC_W)
  ) u_arb (
    .req   (pending_q & mask_q),
    .ptr   (arb_ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

`ifdef INT_CTRL_RR_EN
  logic [VEC_W-1:0] ptr_q, ptr_d;

  // Next search starts just past the source being acknowledged.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == REQ && irq_ack) begin
      ptr_d = (vec_q == VEC_W'(N_SRC - 1)) ? '0 : vec_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign arb_ptr = ptr_q;
`else
  assign arb_ptr = '0;
`endif

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    vec_d   = vec_q;
    mask_d  = mask_q;
    clr     = '0;

    if (mask_we) mask_d = mask_in;

    case (state_q)
      // The arbiter looks at registered pending bits, so a pulse reaches irq
      // one edge after it is latched.
      IDLE: begin
        if (arb_valid) begin
          vec_d   = arb_grant;
          irq_d   = 1'b1;
          state_d = REQ;
        end
      end
      // vec is frozen here; mask writes and new pulses only touch pending.
      REQ: begin
        if (irq_ack) begin
          clr     = N_SRC'(1) << vec_q;
          irq_d   = 1'b0;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi) state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // OR-ing the new pulses after the clear lets a coincident set win.
    pending_d = (pending_q & ~clr) | int_src;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      vec_q     <= '0;
      mask_q    <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      vec_q     <= vec_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
    end
  end

  assign irq        = irq_q;
  assign irq_vec    = vec_q;
  assign in_service = (state_q == SERVICE);
  assign pending    = pending_q;

endmodule : int_ctrl

// File: tb/tb_int_ctrl.sv
// ----------------------------------------------------------------------------
// tb_int_ctrl -- directed self-checking bench for int_ctrl (N_SRC = 8).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// ----------------------------------------------------------------------------
module tb_int_ctrl;

  localparam int N_SRC = 8;
  localparam int VEC_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_SRC-1:0] int_src = '0;
  logic [N_SRC-1:0] mask_in = '0;
  logic             mask_we = 1'b0;
  logic             irq_ack = 1'b0;
  logic             eoi = 1'b0;
  logic             irq;
  logic [VEC_W-1:0] irq_vec;
  logic             in_service;
  logic [N_SRC-1:0] pending;

  int n_cmp = 0;
  int n_err = 0;

  // Expected order for the simultaneous src 2 / src 6 case. With round-robin
  // the pointer sits at 3 after a lone src 2 grant, so src 6 wins first.
`ifdef INT_CTRL_RR_EN
  localparam logic [31:0] FIRST_VEC  = 32'd6;
  localparam logic [31:0] SECOND_VEC = 32'd2;
`else
  localparam logic [31:0] FIRST_VEC  = 32'd2;
  localparam logic [31:0] SECOND_VEC = 32'd6;
`endif

  int_ctrl #(
    .N_SRC (N_SRC),
    .VEC_W (VEC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .int_src    (int_src),
    .mask_in    (mask_in),
    .mask_we    (mask_we),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .irq        (irq),
    .irq_vec    (irq_vec),
    .in_service (in_service),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_mask(input logic [N_SRC-1:0] m);
    mask_in = m;
    mask_we = 1'b1;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic pulse(input logic [N_SRC-1:0] s);
    int_src = s;
    tick();
    int_src = '0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic end_int();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  initial begin
    // Reset with pulses present: they must be discarded.
    int_src = 8'h02;
    repeat (3) tick();
    int_src = '0;
    rst = 1'b0;
    check("rst_pending", 32'(pending), 32'h00);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_vec", 32'(irq_vec), 32'd0);
    check("rst_insvc", 32'(in_service), 32'd0);

    // Basic flow on src 3.
    write_mask(8'hFF);
    pulse(8'h08);
    check("s3_pending", 32'(pending), 32'h08);
    check("s3_irq_early", 32'(irq), 32'd0);
    tick();
    check("s3_irq", 32'(irq), 32'd1);
    check("s3_vec", 32'(irq_vec), 32'd3);

    // eoi in REQ is ignored.
    end_int();
    check("eoi_in_req_irq", 32'(irq), 32'd1);
    check("eoi_in_req_pend", 32'(pending), 32'h08);
    check("eoi_in_req_insvc", 32'(in_service), 32'd0);

    // A new pulse in REQ does not disturb the presented vector.
    pulse(8'h02);
    check("req_newpulse_vec", 32'(irq_vec), 32'd3);
    check("req_newpulse_irq", 32'(irq), 32'd1);
    check("req_newpulse_pend", 32'(pending), 32'h0A);

    ack();
    check("s3_ack_pend", 32'(pending), 32'h02);
    check("s3_ack_insvc", 32'(in_service), 32'd1);
    check("s3_ack_irq", 32'(irq), 32'd0);
    end_int();
    check("s3_eoi_insvc", 32'(in_service), 32'd0);
    check("s3_eoi_irq", 32'(irq), 32'd0);

    // irq_ack in IDLE is ignored; src 1 is then presented.
    ack();
    check("ack_idle_pend", 32'(pending), 32'h02);
    check("ack_idle_irq", 32'(irq), 32'd1);
    check("ack_idle_vec", 32'(irq_vec), 32'd1);
    ack();
    end_int();
    check("s1_done_pend", 32'(pending), 32'h00);

    // Masked source persists and is presented once enabled.
    write_mask(8'h00);
    pulse(8'h20);
    check("m5_pending", 32'(pending), 32'h20);
    tick();
    check("m5_irq_masked", 32'(irq), 32'd0);
    write_mask(8'h20);
    check("m5_irq_unmask_edge", 32'(irq), 32'd0);
    tick();
    check("m5_irq", 32'(irq), 32'd1);
    check("m5_vec", 32'(irq_vec), 32'd5);
    ack();
    end_int();

    // Lone src 2, then src 2 and src 6 together.
    write_mask(8'hFF);
    pulse(8'h04);
    tick();
    check("lone2_vec", 32'(irq_vec), 32'd2);
    ack();
    end_int();
    pulse(8'h44);
    check("dual_pending", 32'(pending), 32'h44);
    tick();
    check("dual_first_irq", 32'(irq), 32'd1);
    check("dual_first_vec", 32'(irq_vec), FIRST_VEC);
    ack();
    check("dual_first_ack_pend", 32'(pending), 32'h44 & ~(32'd1 << FIRST_VEC));
    end_int();
    check("dual_idle_entry_irq", 32'(irq), 32'd0);
    tick();
    check("dual_second_irq", 32'(irq), 32'd1);
    check("dual_second_vec", 32'(irq_vec), SECOND_VEC);
    ack();
    end_int();

    // Coincident ack and set on the presented source: set wins.
    pulse(8'h10);
    tick();
    check("s4_vec", 32'(irq_vec), 32'd4);
    write_mask(8'h00);
    check("s4_maskwr_irq", 32'(irq), 32'd1);
    check("s4_maskwr_vec", 32'(irq_vec), 32'd4);
    write_mask(8'hFF);
    irq_ack = 1'b1;
    int_src = 8'h10;
    tick();
    irq_ack = 1'b0;
    int_src = '0;
    check("s4_setwins_pend", 32'(pending), 32'h10);
    check("s4_setwins_insvc", 32'(in_service), 32'd1);
    check("s4_setwins_irq", 32'(irq), 32'd0);
    end_int();
    check("s4_eoi_irq", 32'(irq), 32'd0);
    tick();
    check("s4_reassert_irq", 32'(irq), 32'd1);
    check("s4_reassert_vec", 32'(irq_vec), 32'd4);
    ack();

    // Reset while in SERVICE with pending = 0x81.
    pulse(8'h81);
    check("svc_pend", 32'(pending), 32'h81);
    check("svc_insvc", 32'(in_service), 32'd1);
    rst = 1'b1;
    #2;
    check("arst_pend", 32'(pending), 32'h00);
    check("arst_insvc", 32'(in_service), 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    check("arst_vec", 32'(irq_vec), 32'd0);
    int_src = 8'hFF;
    tick();
    int_src = '0;
    rst = 1'b0;
    check("arst_pulse_drop", 32'(pending), 32'h00);
    repeat (3) tick();
    check("post_rst_irq", 32'(irq), 32'd0);

    // Mask came back as all-disabled: a pulse alone raises no irq.
    pulse(8'h02);
    tick();
    check("post_rst_mask0_irq", 32'(irq), 32'd0);
    check("post_rst_pend", 32'(pending), 32'h02);
    write_mask(8'hFF);
    tick();
    check("post_rst_irq_on", 32'(irq), 32'd1);
    check("post_rst_vec", 32'(irq_vec), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_int_ctrl
